// File: rtl/alu_op_sequencer.sv
// Master-side sequencer for an external 8-bit ALU: buffers commands in a FIFO, issues them against the accumulator and returns each result on a response stream.
// Optional feature macro: ALU_SEQ_OPCOUNT_EN adds a 16-bit op_count of completed response handshakes.
module alu_op_sequencer #(
  parameter int WIDTH      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_load,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_operand,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
`ifdef ALU_SEQ_OPCOUNT_EN
  output logic [15:0]      op_count,
`endif
  output logic             busy
);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W = WIDTH + 4;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  state_t state, state_next;

  logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]     wr_ptr, rd_ptr;
  logic               full, empty, push, pop;
  logic [ENTRY_W-1:0] head;
  logic               cur_load;
  logic [WIDTH-1:0]   acc, issue_value;

  // The extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
  assign empty       = (wr_ptr == rd_ptr);
  assign full        = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                       (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign cmd_ready   = !full;
  assign push        = cmd_valid && cmd_ready;
  assign pop         = (state == IDLE) && !empty;
  assign head        = fifo_mem[rd_ptr[PTR_W-1:0]];
  assign busy        = (state != IDLE) || !empty;
  assign alu_a       = acc;
  assign issue_value = cur_load ? alu_b : alu_result;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr[PTR_W-1:0]] <= {cmd_load, cmd_op, cmd_operand};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!empty) state_next = ISSUE;
      ISSUE:   state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand/opcode registers double as the ALU drive, so the ALU never sees cmd_* directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_load  <= 1'b0;
      alu_op    <= '0;
      alu_b     <= '0;
      acc       <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_zero  <= 1'b0;
    end else begin
      if (pop) begin
        {cur_load, alu_op, alu_b} <= head;
      end
      if (state == ISSUE) begin
        acc       <= issue_value;
        rsp_data  <= issue_value;
        rsp_zero  <= (issue_value == '0);
        rsp_valid <= 1'b1;
      end else if ((state == RESP) && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef ALU_SEQ_OPCOUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       op_count <= '0;
    else if (rsp_valid && rsp_ready)  op_count <= op_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: behavioural ALU, queue-based reference model
// checked every cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_alu_op_sequencer;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_load = 1'b0;
  logic [2:0] cmd_op = 3'd0;
  logic [7:0] cmd_operand = 8'd0;
  logic [7:0] alu_a, alu_b, alu_result;
  logic [2:0] alu_op;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic       rsp_zero;
  logic       busy;
`ifdef ALU_SEQ_OPCOUNT_EN
  logic [15:0] op_count;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.WIDTH(WIDTH), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_load(cmd_load), .cmd_op(cmd_op), .cmd_operand(cmd_operand),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero),
`ifdef ALU_SEQ_OPCOUNT_EN
    .op_count(op_count),
`endif
    .busy(busy)
  );

  function automatic logic [7:0] alu_fn(input logic [2:0] op, input logic [7:0] a,
                                        input logic [7:0] b);
    logic [7:0] r;
    case (op)
      3'd0:    r = a + b;
      3'd1:    r = a - b;
      3'd2:    r = ~a;
      3'd3:    r = ~(a & b);
      3'd4:    r = ~(a | b);
      3'd5:    r = a & b;
      3'd6:    r = a | b;
      default: r = a ^ b;
    endcase
    return r;
  endfunction

  // Stand-in for the combinational ALU the sequencer drives.
  assign alu_result = alu_fn(alu_op, alu_a, alu_b);

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: a command queue plus one active command that is first issued, then presented.
  typedef struct packed { logic ld; logic [2:0] op; logic [7:0] opd; } cmd_t;
  cmd_t       mq[$];
  cmd_t       m_cur = '0;
  bit         m_active = 1'b0;
  bit         m_presented = 1'b0;
  logic [7:0] m_acc = 8'd0;
  logic [7:0] m_rsp = 8'd0;
  int         m_done = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_cur = '0;
      m_active = 1'b0;
      m_presented = 1'b0;
      m_acc = 8'd0;
      m_rsp = 8'd0;
      m_done = 0;
    end else begin
      bit   accept;
      cmd_t incoming;
      accept = cmd_valid && (mq.size() < DEPTH);
      incoming = {cmd_load, cmd_op, cmd_operand};
      if (!m_active) begin
        if (mq.size() > 0) begin
          m_cur = mq.pop_front();
          m_active = 1'b1;
          m_presented = 1'b0;
        end
      end else if (!m_presented) begin
        m_acc = m_cur.ld ? m_cur.opd : alu_fn(m_cur.op, m_acc, m_cur.opd);
        m_rsp = m_acc;
        m_presented = 1'b1;
      end else if (rsp_ready) begin
        m_active = 1'b0;
        m_presented = 1'b0;
        m_done++;
      end
      if (accept) mq.push_back(incoming);
    end
  end

  always @(negedge clk) begin
    checkOutput("cmd_ready", 32'(cmd_ready), 32'(mq.size() < DEPTH));
    checkOutput("busy", 32'(busy), 32'(m_active || (mq.size() > 0)));
    checkOutput("rsp_valid", 32'(rsp_valid), 32'(m_active && m_presented));
    if (m_active && m_presented) begin
      checkOutput("rsp_data", 32'(rsp_data), 32'(m_rsp));
      checkOutput("rsp_zero", 32'(rsp_zero), 32'(m_rsp == 8'd0));
    end
    checkOutput("alu_a", 32'(alu_a), 32'(m_acc));
    checkOutput("alu_b", 32'(alu_b), 32'(m_cur.opd));
    checkOutput("alu_op", 32'(alu_op), 32'(m_cur.op));
`ifdef ALU_SEQ_OPCOUNT_EN
    checkOutput("op_count", 32'(op_count), 32'(m_done[15:0]));
`endif
  end

  // Called at a falling edge; returns at the falling edge after the accepting rising edge.
  task automatic applyStimulus(input logic ld, input logic [2:0] op, input logic [7:0] opd,
                               output bit ok);
    cmd_load = ld;
    cmd_op = op;
    cmd_operand = opd;
    cmd_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (cmd_ready) ok = 1'b1;
      @(negedge clk);
    end
    if (!ok) checkOutput("push_timeout", 32'(cmd_ready), 32'd1);
  endtask

  task automatic waitResponse(input logic [7:0] exp_data, input logic exp_zero,
                              input string name, output int waited);
    waited = 0;
    while (!rsp_valid && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (!rsp_valid) begin
      checkOutput({name, "_timeout"}, 32'(rsp_valid), 32'd1);
    end else begin
      checkOutput(name, 32'(rsp_data), 32'(exp_data));
      checkOutput({name, "_zero"}, 32'(rsp_zero), 32'(exp_zero));
      if (rsp_ready) @(negedge clk);
    end
  endtask

  initial begin
    int waited;
    bit ok;

    repeat (3) @(negedge clk);
    checkOutput("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_alu_a", 32'(alu_a), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] load then latency");
    rsp_ready = 1'b1;
    applyStimulus(1'b1, 3'd0, 8'h0F, ok);
    cmd_valid = 1'b0;
    waitResponse(8'h0F, 1'b0, "t1_load", waited);
    checkOutput("t1_latency", 32'(waited), 32'd2);

    $display("[TB] add wraps modulo 256");
    applyStimulus(1'b1, 3'd0, 8'hF0, ok);
    cmd_valid = 1'b0;
    waitResponse(8'hF0, 1'b0, "t2_load", waited);
    applyStimulus(1'b0, 3'd0, 8'h20, ok);
    cmd_valid = 1'b0;
    @(negedge clk);
    checkOutput("t2_issue_a", 32'(alu_a), 32'h0F0);
    checkOutput("t2_issue_b", 32'(alu_b), 32'h020);
    checkOutput("t2_issue_op", 32'(alu_op), 32'd0);
    waitResponse(8'h10, 1'b0, "t2_add", waited);

    $display("[TB] sub to zero, then not");
    rsp_ready = 1'b0;
    applyStimulus(1'b1, 3'd0, 8'h10, ok);
    applyStimulus(1'b0, 3'd1, 8'h10, ok);
    applyStimulus(1'b0, 3'd2, 8'h55, ok);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    waitResponse(8'h10, 1'b0, "t3_load", waited);
    waitResponse(8'h00, 1'b1, "t3_sub", waited);
    waitResponse(8'hFF, 1'b0, "t3_not", waited);

    $display("[TB] backpressure fills FIFO");
    rsp_ready = 1'b0;
    applyStimulus(1'b1, 3'd0, 8'h01, ok);
    applyStimulus(1'b0, 3'd0, 8'h02, ok);
    applyStimulus(1'b0, 3'd7, 8'hFF, ok);
    applyStimulus(1'b0, 3'd5, 8'h0F, ok);
    applyStimulus(1'b0, 3'd6, 8'h30, ok);
    cmd_load = 1'b0; cmd_op = 3'd0; cmd_operand = 8'h77; cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checkOutput("t4_ready_low", 32'(cmd_ready), 32'd0);
      checkOutput("t4_hold_data", 32'(rsp_data), 32'h01);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    waitResponse(8'h01, 1'b0, "t4_r1", waited);
    waitResponse(8'h03, 1'b0, "t4_r2", waited);
    waitResponse(8'hFC, 1'b0, "t4_r3", waited);
    waitResponse(8'h0C, 1'b0, "t4_r4", waited);
    waitResponse(8'h3C, 1'b0, "t4_r5", waited);

    $display("[TB] reset during issue");
    rsp_ready = 1'b0;
    applyStimulus(1'b1, 3'd0, 8'hAA, ok);
    for (int i = 1; i <= 4; i++) applyStimulus(1'b0, 3'd0, 8'(i), ok);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("t5_busy_before", 32'(busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("t5_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("t5_alu_a", 32'(alu_a), 32'd0);
    checkOutput("t5_alu_b", 32'(alu_b), 32'd0);
    checkOutput("t5_alu_op", 32'(alu_op), 32'd0);
    checkOutput("t5_rsp_data", 32'(rsp_data), 32'd0);
    checkOutput("t5_busy", 32'(busy), 32'd0);
    checkOutput("t5_cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checkOutput("t5_no_stale_rsp", 32'(rsp_valid), 32'd0);
      checkOutput("t5_idle", 32'(busy), 32'd0);
      @(negedge clk);
    end

    $display("[TB] randomized traffic");
    for (int c = 0; c < 3000; c++) begin
      cmd_valid   = ($urandom_range(0, 99) < 55);
      cmd_load    = ($urandom_range(0, 4) == 0);
      cmd_op      = 3'($urandom_range(0, 7));
      cmd_operand = 8'($urandom);
      rsp_ready   = ($urandom_range(0, 99) < 65);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (30) @(negedge clk);
    checkOutput("drain_idle", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
